fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the pipelined core. Replaces the bare PC register/adder path.

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared constants and types for the instruction-fetch front
//                end: default widths, FSM state encoding and the decode NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Default PC width and PC of the first fetch after reset
    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch FSM encoding
    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    // Bubble instruction used by decode (addi x0, x0, 0); not used by fetch
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Width of a queue pointer / occupancy counter for a power-of-2 depth:
    // one extra MSB distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous prefetch queue with flush. Pointers carry one
//                extra MSB so full and empty are distinguished without a
//                separate counter. Push and pop in the same cycle are allowed
//                even when full (the popped slot is the one being refilled).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            push,
    input  logic                            pop,
    input  logic [WIDTH-1:0]                push_data,
    output logic [WIDTH-1:0]                pop_data,
    output logic                            full,
    output logic                            empty,
    output logic [ptr_width(DEPTH)-1:0]     count
);

    localparam int c_pw = ptr_width(DEPTH);
    localparam int c_aw = c_pw - 1;

    logic [c_pw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_pw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                      (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_ptr_q[c_aw-1:0]];

    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    // Next pointers and storage; flush empties the queue and wins over push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_push_ok) begin
                mem_d[wr_ptr_q[c_aw-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + c_pw'(1);
            end
            if (w_pop_ok) begin
                rd_ptr_d = rd_ptr_q + c_pw'(1);
            end
        end
    end

    // Pointer and storage registers; storage contents need no reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch front end. Issues in-order requests to a
//                variable-latency instruction memory under a credit limit,
//                queues returned words with their PC, hands {instr, pc, pc+4}
//                to decode and flushes on execute redirects.
//                Optional build macro FETCH_PERF_EN adds perf_fetched and
//                perf_flushed event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            hlt,
    output logic            halted,
    output logic            instrD_valid,
    input  logic            instrD_ready,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcplus4D
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int            c_pw    = ptr_width(DEPTH);
    localparam int            c_fw    = 32 + XLEN;
    localparam logic [c_pw:0] c_depth = (c_pw+1)'(DEPTH);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [c_pw-1:0]  outstanding_q, outstanding_d;
    logic [c_pw-1:0]  drop_q, drop_d;

    logic             w_rsp;
    logic             w_redirect;
    logic [c_pw:0]    w_inflight;
    logic             w_credit;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp_drop;
    logic             w_push;
    logic             w_pop;
    logic             w_dvalid;
    logic [XLEN-1:0]  w_target;
    logic [c_pw-1:0]  w_count;
    logic             w_full;
    logic             w_empty;
    logic [c_fw-1:0]  w_pop_data;
    logic [2:0]       w_unused_bits;

    // Inputs are ignored while reset is held
    assign w_rsp      = reset && imem_rsp_valid;
    assign w_redirect = reset && redirect_valid;
    assign w_target   = {redirect_pc[XLEN-1:2], 2'b00};

    // A request is only issued when the queue can absorb every reply in flight
    assign w_inflight  = {1'b0, w_count} + {1'b0, outstanding_q};
    assign w_credit    = (w_inflight < c_depth);
    assign w_req_valid = reset && (state_q == FETCH_RUN) && !w_redirect && w_credit;
    assign w_req_fire  = w_req_valid && imem_req_ready;

    // Replies belonging to a flushed path are dropped, including one that
    // lands in the redirect cycle itself
    assign w_rsp_drop = w_rsp && ((drop_q != '0) || w_redirect);
    assign w_push     = w_rsp && !w_rsp_drop;

    assign w_dvalid = reset && !w_empty && !w_redirect;
    assign w_pop    = w_dvalid && instrD_ready;

    assign w_unused_bits = {w_full, redirect_pc[1:0]};

    fetch_fifo #(
        .WIDTH (c_fw),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_redirect),
        .push      (w_push),
        .pop       (w_pop),
        .push_data ({imem_rsp_data, rsp_pc_q}),
        .pop_data  (w_pop_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Next-state for PCs, credit/drop counters and the run/halt FSM
    always_comb begin
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + c_pw'(w_req_fire) - c_pw'(w_rsp);

        if (w_redirect) begin
            // no request fires in a redirect cycle, so this is the count left after it
            drop_d   = outstanding_q - c_pw'(w_rsp);
            req_pc_d = w_target;
            rsp_pc_d = w_target;
        end else begin
            if (w_rsp && (drop_q != '0)) begin
                drop_d = drop_q - c_pw'(1);
            end
            if (w_req_fire) begin
                req_pc_d = req_pc_q + XLEN'(4);
            end
            if (w_push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
        end

        case (state_q)
            FETCH_RUN:  if (hlt)  state_d = FETCH_HALT;
            FETCH_HALT: if (!hlt) state_d = FETCH_RUN;
            default:    state_d = FETCH_RUN;
        endcase
    end

    // Fetch control registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH_RUN;
            req_pc_q      <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Every output reads zero while reset is held
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = reset ? req_pc_q : '0;
    assign halted         = reset && (state_q == FETCH_HALT) && (outstanding_q == '0);
    assign instrD_valid   = w_dvalid;
    assign instrD         = reset ? w_pop_data[c_fw-1:XLEN] : '0;
    assign pcD            = reset ? w_pop_data[XLEN-1:0] : '0;
    assign pcplus4D       = reset ? (w_pop_data[XLEN-1:0] + XLEN'(4)) : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    // Count decode handshakes and every word discarded by a flush
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(w_pop);
        perf_flushed_d = perf_flushed_q + 32'(w_rsp_drop)
                       + (w_redirect ? 32'(w_count) : 32'd0);
    end

    // Performance counter registers, wrap modulo 2^32
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = reset ? perf_fetched_q : '0;
    assign perf_flushed = reset ? perf_flushed_q : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit with an in-order
//                variable-latency instruction memory model. Memory returns
//                ~addr as the instruction word so each decoded word can be
//                tied back to its PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        hlt;
    logic        halted;
    logic        instrD_valid;
    logic        instrD_ready;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcplus4D;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFF8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hlt            (hlt),
        .halted         (halted),
        .instrD_valid   (instrD_valid),
        .instrD_ready   (instrD_ready),
        .instrD         (instrD),
        .pcD            (pcD),
        .pcplus4D       (pcplus4D)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] req_log[$];
    logic [31:0] dec_pc[$];
    int          cyc;
    int          lat;
    int          n_checks;
    int          n_fail;
    logic        obs_req_valid;
    logic        obs_dvalid;
    logic        obs_halted;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // One clock cycle, entered and left at a falling edge
    task automatic tick();
        req_t r;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mq[0].addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        obs_req_valid = imem_req_valid;
        obs_dvalid    = instrD_valid;
        obs_halted    = halted;
        if (imem_rsp_valid) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            r.addr = imem_req_addr;
            r.due  = cyc + lat;
            mq.push_back(r);
            req_log.push_back(imem_req_addr);
        end
        if (instrD_valid && instrD_ready) begin
            dec_pc.push_back(pcD);
            check_eq("instr_word", instrD, ~pcD);
            check_eq("pcplus4", pcplus4D, pcD + 32'd4);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic restart(input int latency);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        hlt            = 1'b0;
        imem_req_ready = 1'b1;
        instrD_ready   = 1'b1;
        lat            = latency;
        mq.delete();
        tick();
        tick();
        mq.delete();
        req_log.delete();
        dec_pc.delete();
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check_eq({tag, "_req_addr"},  imem_req_addr,       32'd0);
        check_eq({tag, "_dvalid"},    32'(instrD_valid),   32'd0);
        check_eq({tag, "_pcD"},       pcD,                 32'd0);
        check_eq({tag, "_pcplus4D"},  pcplus4D,            32'd0);
        check_eq({tag, "_halted"},    32'(halted),         32'd0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        cyc            = 0;
        lat            = 1;
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        hlt            = 1'b0;
        instrD_ready   = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("rst");
`ifdef FETCH_PERF_EN
        check_eq("rst_perf_fetched", perf_fetched, 32'd0);
`endif

        // 1: streaming, latency 1, PC wraps past 2^32
        restart(1);
        for (int i = 0; i < 8; i++) tick();
        check_eq("t1_nreq",  32'(req_log.size()), 32'd8);
        check_eq("t1_ndec",  32'(dec_pc.size()),  32'd6);
        check_eq("t1_req0",  q_at(req_log, 0), 32'hFFFF_FFF8);
        check_eq("t1_req1",  q_at(req_log, 1), 32'hFFFF_FFFC);
        check_eq("t1_req2",  q_at(req_log, 2), 32'h0000_0000);
        check_eq("t1_req3",  q_at(req_log, 3), 32'h0000_0004);
        check_eq("t1_dec0",  q_at(dec_pc, 0),  32'hFFFF_FFF8);
        check_eq("t1_dec2",  q_at(dec_pc, 2),  32'h0000_0000);
        check_eq("t1_dec5",  q_at(dec_pc, 5),  32'h0000_000C);

        // 2: decode stalled, credit limits issue to DEPTH requests
        restart(1);
        instrD_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("t2_nreq",  32'(req_log.size()), 32'd4);
        check_eq("t2_reqv",  32'(obs_req_valid),  32'd0);
        check_eq("t2_dvalid", 32'(obs_dvalid),    32'd1);
        instrD_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_eq("t2_dec0",  q_at(dec_pc, 0), 32'hFFFF_FFF8);
        check_eq("t2_dec1",  q_at(dec_pc, 1), 32'hFFFF_FFFC);
        check_eq("t2_dec2",  q_at(dec_pc, 2), 32'h0000_0000);
        check_eq("t2_dec3",  q_at(dec_pc, 3), 32'h0000_0004);
        check_eq("t2_dec4",  q_at(dec_pc, 4), 32'h0000_0008);

        // 3: redirect with two replies outstanding, latency 3
        restart(3);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        check_eq("t3_redir_reqv", 32'(obs_req_valid), 32'd0);
        redirect_valid = 1'b0;
        tick();
        check_eq("t3_dvalid_after", 32'(obs_dvalid), 32'd0);
        for (int i = 0; i < 9; i++) tick();
        check_eq("t3_req_target", q_at(req_log, 2), 32'h0000_0100);
        check_eq("t3_dec0", q_at(dec_pc, 0), 32'h0000_0100);
        check_eq("t3_dec1", q_at(dec_pc, 1), 32'h0000_0104);

        // 4: redirect coincides with a reply and a would-be decode handshake
        restart(1);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        check_eq("t4_no_pop_dvalid", 32'(obs_dvalid), 32'd0);
        check_eq("t4_no_pop_count",  32'(dec_pc.size()), 32'd0);
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("t4_dec0", q_at(dec_pc, 0), 32'h0000_0040);
        check_eq("t4_dec1", q_at(dec_pc, 1), 32'h0000_0044);

        // 5: halt with three requests outstanding, latency 4
        restart(4);
        tick();
        tick();
        hlt = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check_eq("t5_halted_early", 32'(obs_halted), 32'd0);
        tick();
        check_eq("t5_halted", 32'(obs_halted), 32'd1);
        check_eq("t5_nreq",   32'(req_log.size()), 32'd3);
        hlt = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_eq("t5_resume_pc", q_at(req_log, 3), 32'h0000_0004);
        check_eq("t5_dec2", q_at(dec_pc, 2), 32'h0000_0000);

        // 6: reset asserted mid-burst discards everything
        restart(2);
        instrD_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        #1;
        check_all_zero("t6_midrst");
        tick();
        tick();
        mq.delete();
        req_log.delete();
        dec_pc.delete();
        lat          = 1;
        instrD_ready = 1'b1;
        reset        = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_eq("t6_req0", q_at(req_log, 0), 32'hFFFF_FFF8);
        check_eq("t6_dec0", q_at(dec_pc, 0),  32'hFFFF_FFF8);
        check_eq("t6_dec1", q_at(dec_pc, 1),  32'hFFFF_FFFC);
`ifdef FETCH_PERF_EN
        #1;
        check_eq("t6_perf_fetched", perf_fetched, 32'(dec_pc.size()));
        check_eq("t6_perf_flushed", perf_flushed, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
